decode_sequencer: RTL
=====================

// Module: decode_sequencer
// PURPOSE
//  Decode-stage front end that drives opCode/makeMeBubble into the control unit.
//  - Splits CALL/RET/RTI into their two-part opcode pairs.
//  - Injects the two-part interrupt sequence.
//  - Inserts load-use bubbles and drain bubbles.
//  - Stalls PC and IF/ID while injecting or draining.
// PARAMETERS
//  RET_BUBBLES   2  bubble cycles after RET2/RTI2/INT2 until the memory-sourced PC is valid (0..7)
//  CALL_BUBBLES  0  bubble cycles after CALL2 (0..7)
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  reset, asynchronous, active-low
//  instrOpCode    in   5  opcode field of the IF/ID register
//  instrValid     in   1  IF/ID holds a real instruction (0 = treat as NOP)
//  interruptReq   in   1  external interrupt line, level, synchronous to clk
//  loadUseHazard  in   1  ID/EX is a load whose destination matches a source in ID
//  flush          in   1  EX resolved a taken branch; IF/ID content is wrong-path
//  opCode         out  5  opcode presented to the control unit
//  makeMeBubble   out  1  forces the control unit to emit a bubble
//  pcStall        out  1  hold PC and IF/ID this cycle
//  intAck         out  1  one-cycle pulse when INT2 is issued
// BEHAVIOUR
//  Opcode constants: NOP=00000, CALL=11000, CALL2=11001, RET=11010, RET2=11011,
//  RTI=11100, RTI2=11101, INT1=11110, INT2=11111.
//  Reset (rst=0, async):
//  - state=NORMAL, drainCnt=0, intPending=0, reqPrev=0.
//  - Outputs while in reset: opCode=NOP, makeMeBubble=0, pcStall=0, intAck=0.
//  Outputs are combinational from the registered state plus the inputs.
//  intPending:
//  - Set on a rising edge of interruptReq (reqPrev register); cleared when INT1 issues.
//  - A new edge while pending is absorbed.
//  - flush does not clear it.
//  States: NORMAL, CALL2, RET2, RTI2, INT1, INT2, DRAIN.
//  Priority in every state: flush > loadUseHazard > sequencing.
//  - flush in any state: opCode=NOP, makeMeBubble=1, pcStall=0, next=NORMAL, drainCnt=0.
//    An in-progress CALL/RET/RTI split is abandoned.
//    An in-progress INT1/INT2 restarts: intPending is re-set and INT1 is re-issued from NORMAL.
//  - NORMAL, loadUseHazard=1: makeMeBubble=1, pcStall=1, state unchanged.
//  - NORMAL, intPending=1 and instrOpCode not CALL/RET/RTI: opCode=INT1, pcStall=1, next=INT2.
//    The held IF/ID instruction is re-presented after the drain.
//  - NORMAL, instrOpCode=CALL/RET/RTI (valid): pass the opcode, pcStall=1, next=CALL2/RET2/RTI2.
//  - NORMAL, otherwise: opCode = instrValid ? instrOpCode : NOP; no stall.
//  - CALL2/RET2/RTI2: emit the matching second-part opcode.
//    pcStall = 1 if the following drain count is >0, else 0.
//    next=DRAIN with drainCnt=CALL_BUBBLES or RET_BUBBLES, or NORMAL if that count is 0.
//  - INT2: opCode=INT2, intAck=1, pcStall=1, next=DRAIN with drainCnt=RET_BUBBLES.
//  - DRAIN: makeMeBubble=1, pcStall=1, drainCnt decrements; next=NORMAL when drainCnt reaches 1.
//  - loadUseHazard is ignored outside NORMAL; injected opcodes never consume loaded registers.
//  - A pending interrupt is taken only from NORMAL, so it never splits a two-part pair.
//  Latency: a plain instruction passes through combinationally (0 cycles); no extra delay.
// STRUCTURE
//  Shared package: opcode localparams listed above and the state encoding (3-bit enum).
//  No sub-module. Drain counter width = 3.
// TESTING
//  1. ADD (01001) valid, no hazards -> opCode=01001 same cycle; makeMeBubble=0, pcStall=0.
//  2. CALL (11000) -> cycle0: opCode=11000, pcStall=1; cycle1: opCode=11001, pcStall=0;
//     cycle2: next instruction passes (CALL_BUBBLES=0).
//  3. RET with RET_BUBBLES=2 -> cycle0: 11010; cycle1: 11011; cycles 2-3: makeMeBubble=1,
//     pcStall=1; cycle4: NORMAL.
//  4. interruptReq rises while IF/ID=SUB -> 11110, then 11111 with intAck=1, then 2 bubbles,
//     then SUB is issued.
//  5. interruptReq rises during CALL (cycle0) -> 11000, then 11001, then 11110, then 11111.
//  6. loadUseHazard=1 with ADD -> one cycle with makeMeBubble=1, pcStall=1, then ADD.
//     flush during RET2 -> NOP bubble, state=NORMAL.
//     rst low mid-DRAIN -> outputs immediately NOP/0/0/0.

Source files
------------

// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the decode sequencer: opcode constants, the
// sequencer state encoding and small opcode helpers.
package decode_sequencer_pkg;

    typedef logic [4:0] opcodeT;
    typedef logic [2:0] drainCntT;

    localparam opcodeT OP_NOP   = 5'b00000;
    localparam opcodeT OP_CALL  = 5'b11000;
    localparam opcodeT OP_CALL2 = 5'b11001;
    localparam opcodeT OP_RET   = 5'b11010;
    localparam opcodeT OP_RET2  = 5'b11011;
    localparam opcodeT OP_RTI   = 5'b11100;
    localparam opcodeT OP_RTI2  = 5'b11101;
    localparam opcodeT OP_INT1  = 5'b11110;
    localparam opcodeT OP_INT2  = 5'b11111;

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_CALL2,
        ST_RET2,
        ST_RTI2,
        ST_INT1,
        ST_INT2,
        ST_DRAIN
    } seqStateT;

    function automatic logic isSplitOp(opcodeT op);
        return (op == OP_CALL) || (op == OP_RET) || (op == OP_RTI);
    endfunction

    // State that emits the second half of a split opcode.
    function automatic seqStateT splitState(opcodeT op);
        case (op)
            OP_CALL: return ST_CALL2;
            OP_RET:  return ST_RET2;
            OP_RTI:  return ST_RTI2;
            default: return ST_NORMAL;
        endcase
    endfunction

    function automatic opcodeT secondOp(seqStateT s);
        case (s)
            ST_CALL2: return OP_CALL2;
            ST_RET2:  return OP_RET2;
            ST_RTI2:  return OP_RTI2;
            default:  return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// Decode-stage bus between the IF/ID pipeline side (master) and the
// sequencer that feeds the control unit (slave).
interface decode_sequencer_if;
    import decode_sequencer_pkg::*;

    opcodeT instrOpCode;
    logic   instrValid;
    logic   interruptReq;
    logic   loadUseHazard;
    logic   flush;

    opcodeT opCode;
    logic   makeMeBubble;
    logic   pcStall;
    logic   intAck;

    modport master (
        output instrOpCode, instrValid, interruptReq, loadUseHazard, flush,
        input  opCode, makeMeBubble, pcStall, intAck
    );

    modport slave (
        input  instrOpCode, instrValid, interruptReq, loadUseHazard, flush,
        output opCode, makeMeBubble, pcStall, intAck
    );

endinterface

// File: rtl/decode_sequencer.sv
// Decode-stage sequencer: splits CALL/RET/RTI into opcode pairs, injects the
// INT1/INT2 interrupt pair and inserts load-use and drain bubbles.
module decode_sequencer
    import decode_sequencer_pkg::*;
#(
    parameter int RET_BUBBLES  = 2,
    parameter int CALL_BUBBLES = 0
) (
    input logic               clk,
    input logic               rst,
    decode_sequencer_if.slave bus
);

    localparam drainCntT RET_CNT  = drainCntT'(RET_BUBBLES);
    localparam drainCntT CALL_CNT = drainCntT'(CALL_BUBBLES);

    seqStateT state;
    seqStateT nextState;
    drainCntT drainCnt;
    drainCntT nextDrainCnt;
    drainCntT tailCnt;
    logic     intPending;
    logic     reqPrev;

    opcodeT   opCodeC;
    logic     bubbleC;
    logic     stallC;
    logic     ackC;
    logic     int1Issue;

    logic     splitIn;
    logic     reqEdge;
    logic     intRestart;

    assign splitIn    = bus.instrValid && isSplitOp(bus.instrOpCode);
    assign reqEdge    = bus.interruptReq && !reqPrev;
    // A flush that lands between INT1 and INT2 loses the pair, so re-arm it.
    assign intRestart = bus.flush && ((state == ST_INT1) || (state == ST_INT2));

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        nextState    = state;
        nextDrainCnt = drainCnt;
        tailCnt      = '0;
        opCodeC      = OP_NOP;
        bubbleC      = 1'b0;
        stallC       = 1'b0;
        ackC         = 1'b0;
        int1Issue    = 1'b0;

        if (bus.flush) begin
            bubbleC      = 1'b1;
            nextState    = ST_NORMAL;
            nextDrainCnt = '0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (bus.loadUseHazard) begin
                        bubbleC = 1'b1;
                        stallC  = 1'b1;
                    end else if (intPending && !splitIn) begin
                        opCodeC   = OP_INT1;
                        stallC    = 1'b1;
                        int1Issue = 1'b1;
                        nextState = ST_INT2;
                    end else if (splitIn) begin
                        opCodeC   = bus.instrOpCode;
                        stallC    = 1'b1;
                        nextState = splitState(bus.instrOpCode);
                    end else begin
                        opCodeC = bus.instrValid ? bus.instrOpCode : OP_NOP;
                    end
                end

                ST_CALL2, ST_RET2, ST_RTI2: begin
                    tailCnt      = (state == ST_CALL2) ? CALL_CNT : RET_CNT;
                    opCodeC      = secondOp(state);
                    stallC       = (tailCnt != '0);
                    nextDrainCnt = tailCnt;
                    nextState    = (tailCnt != '0) ? ST_DRAIN : ST_NORMAL;
                end

                ST_INT1: begin
                    opCodeC   = OP_INT1;
                    stallC    = 1'b1;
                    int1Issue = 1'b1;
                    nextState = ST_INT2;
                end

                ST_INT2: begin
                    opCodeC      = OP_INT2;
                    ackC         = 1'b1;
                    stallC       = 1'b1;
                    nextDrainCnt = RET_CNT;
                    nextState    = (RET_CNT != '0) ? ST_DRAIN : ST_NORMAL;
                end

                ST_DRAIN: begin
                    bubbleC      = 1'b1;
                    stallC       = 1'b1;
                    nextDrainCnt = drainCnt - 3'd1;
                    if (drainCnt <= 3'd1) begin
                        nextState    = ST_NORMAL;
                        nextDrainCnt = '0;
                    end
                end

                default: begin
                    nextState    = ST_NORMAL;
                    nextDrainCnt = '0;
                end
            endcase
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_NORMAL;
            drainCnt   <= '0;
            intPending <= 1'b0;
            reqPrev    <= 1'b0;
        end else begin
            state    <= nextState;
            drainCnt <= nextDrainCnt;
            reqPrev  <= bus.interruptReq;
            if (int1Issue) begin
                intPending <= 1'b0;
            end else if (reqEdge || intRestart) begin
                intPending <= 1'b1;
            end
        end
    end

    // Outputs are forced idle for as long as reset is held.
    assign bus.opCode       = rst ? opCodeC : OP_NOP;
    assign bus.makeMeBubble = rst & bubbleC;
    assign bus.pcStall      = rst & stallC;
    assign bus.intAck       = rst & ackC;

endmodule
